green_interp_pipe: RTL and testbench



---
 rtl/green_interp_pipe_if.sv | 50 +++++
 rtl/green_interp_pipe.sv | 260 ++++++++++++++++++++++++++
 tb/tb_green_interp_pipe.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/green_interp_pipe_if.sv
// ---------------------------------------------------------------------------
// green_interp_pipe_if
// Streaming bundle for the pipelined green interpolator.
//   in_valid / in_ready     : window handshake (ready driven by the pipe)
//   in_is_green             : centre pixel is a green site
//   p_m2_p0 .. p_p2_p0      : vertical taps N2, N1, S1, S2
//   p_p0_m2 .. p_p0_p2      : horizontal taps W2, W1, E1, E2
//   p_p0_p0                 : centre tap C
//   dir_th                  : direction threshold, travels with the window
//   out_valid / out_ready   : result handshake (valid driven by the pipe)
//   green                   : interpolated green result
// Modports: master = window source / result sink, slave = the pipe.
// ---------------------------------------------------------------------------
interface green_interp_pipe_if #(
    parameter int PW   = 12,
    parameter int TH_W = 8
);
    logic            in_valid;
    logic            in_ready;
    logic            in_is_green;
    logic [PW-1:0]   p_m2_p0;
    logic [PW-1:0]   p_m1_p0;
    logic [PW-1:0]   p_p1_p0;
    logic [PW-1:0]   p_p2_p0;
    logic [PW-1:0]   p_p0_m2;
    logic [PW-1:0]   p_p0_m1;
    logic [PW-1:0]   p_p0_p1;
    logic [PW-1:0]   p_p0_p2;
    logic [PW-1:0]   p_p0_p0;
    logic [TH_W-1:0] dir_th;
    logic            out_valid;
    logic            out_ready;
    logic [PW-1:0]   green;

    modport master (
        output in_valid, in_is_green,
        output p_m2_p0, p_m1_p0, p_p1_p0, p_p2_p0,
        output p_p0_m2, p_p0_m1, p_p0_p1, p_p0_p2, p_p0_p0,
        output dir_th, out_ready,
        input  in_ready, out_valid, green
    );

    modport slave (
        input  in_valid, in_is_green,
        input  p_m2_p0, p_m1_p0, p_p1_p0, p_p2_p0,
        input  p_p0_m2, p_p0_m1, p_p0_p1, p_p0_p2, p_p0_p0,
        input  dir_th, out_ready,
        output in_ready, out_valid, green
    );
endinterface

// File: rtl/green_interp_pipe.sv
// ---------------------------------------------------------------------------
// green_interp_pipe
// Three-stage pipelined Hamilton-Adams green interpolator for a Bayer CFA.
// Takes a 9-tap cross window, forms horizontal and vertical estimates, picks
// a direction from the gradients (or blends on a near-tie) and clamps the
// result to the pixel range. Green sites pass the centre tap through.
//
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   bus (slave)     : window/result streaming bundle (green_interp_pipe_if)
//   cnt_clr         : synchronous clear of the decision counters
//   cnt_h/v/b       : counts of delivered H / V / blended decisions
//
// Optional feature: define GREEN_INTERP_STATS_EN to build the saturating
// decision counters. Without it the counter outputs are constant zero and
// cnt_clr has no effect.
// ---------------------------------------------------------------------------
module green_interp_pipe #(
    parameter int PW    = 12,
    parameter int TH_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    green_interp_pipe_if.slave   bus,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     cnt_h,
    output logic [CNT_W-1:0]     cnt_v,
    output logic [CNT_W-1:0]     cnt_b
);
    localparam int SW = PW + 1;                          // neighbour pair sums
    localparam int LW = PW + 3;                          // Laplacian terms (signed)
    localparam int NW = PW + 4;                          // 4x estimates (signed)
    localparam int CW = ((LW > TH_W) ? LW : TH_W) + 1;   // gradient compare width

    typedef enum logic [1:0] {
        SEL_H = 2'd0,
        SEL_V = 2'd1,
        SEL_B = 2'd2
    } sel_t;

    // Whole pipe advances together; a full output stage blocks everything.
    logic en;

    // Stage 1
    logic            v1_q, v1_d, g1_q, g1_d;
    logic [PW-1:0]   c1_q, c1_d;
    logic [TH_W-1:0] th1_q, th1_d;
    logic [SW-1:0]   sh1_q, sh1_d, sv1_q, sv1_d;
    logic [LW-1:0]   lh1_q, lh1_d, lv1_q, lv1_d;
    logic [PW-1:0]   ah1_q, ah1_d, av1_q, av1_d;
    // Stage 2
    logic            v2_q, v2_d, g2_q, g2_d;
    logic [PW-1:0]   c2_q, c2_d;
    logic [NW-1:0]   nh2_q, nh2_d, nv2_q, nv2_d;
    sel_t            sel2_q, sel2_d;
    // Stage 3 (output)
    logic            out_valid_q, out_valid_d;
    logic [PW-1:0]   green_q, green_d;

    // Combinational datapath values
    logic [LW-1:0]   dh_c, dv_c;
    logic [CW-1:0]   dhw_c, dvw_c, thw_c;
    sel_t            sel_c;
    logic [PW-1:0]   gh_c, gv_c, res_c;
    logic [PW:0]     blend_c;

    function automatic logic [LW-1:0] abs_lw(input logic [LW-1:0] x);
        return x[LW-1] ? (~x + LW'(1)) : x;
    endfunction

    // floor(n/4) then clamp to [0, 2^PW-1]
    function automatic logic [PW-1:0] shift_clamp(input logic [NW-1:0] n);
        logic [NW-1:0] q;
        q = {{2{n[NW-1]}}, n[NW-1:2]};
        if (q[NW-1])
            return '0;
        else if (|q[NW-2:PW])
            return '1;
        else
            return q[PW-1:0];
    endfunction

    assign en            = bus.out_ready | ~out_valid_q;
    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.green     = green_q;

    always_comb begin
        // Stage 2 gradients: first-derivative plus |Laplacian| per direction.
        dh_c  = {3'b000, ah1_q} + abs_lw(lh1_q);
        dv_c  = {3'b000, av1_q} + abs_lw(lv1_q);
        dhw_c = CW'(dh_c);
        dvw_c = CW'(dv_c);
        thw_c = CW'(th1_q);
        if ((dhw_c + thw_c) < dvw_c)
            sel_c = SEL_H;
        else if ((dvw_c + thw_c) < dhw_c)
            sel_c = SEL_V;
        else
            sel_c = SEL_B;

        // Stage 3 estimates and final pick
        gh_c    = shift_clamp(nh2_q);
        gv_c    = shift_clamp(nv2_q);
        blend_c = {1'b0, gh_c} + {1'b0, gv_c} + (PW+1)'(1);
        case (sel2_q)
            SEL_H:   res_c = gh_c;
            SEL_V:   res_c = gv_c;
            default: res_c = blend_c[PW:1];
        endcase
    end

    always_comb begin
        v1_d        = v1_q;
        g1_d        = g1_q;
        c1_d        = c1_q;
        th1_d       = th1_q;
        sh1_d       = sh1_q;
        sv1_d       = sv1_q;
        lh1_d       = lh1_q;
        lv1_d       = lv1_q;
        ah1_d       = ah1_q;
        av1_d       = av1_q;
        v2_d        = v2_q;
        g2_d        = g2_q;
        c2_d        = c2_q;
        nh2_d       = nh2_q;
        nv2_d       = nv2_q;
        sel2_d      = sel2_q;
        out_valid_d = out_valid_q;
        green_d     = green_q;
        if (en) begin
            v1_d  = bus.in_valid;
            g1_d  = bus.in_is_green;
            c1_d  = bus.p_p0_p0;
            th1_d = bus.dir_th;
            sh1_d = {1'b0, bus.p_p0_m1} + {1'b0, bus.p_p0_p1};
            sv1_d = {1'b0, bus.p_m1_p0} + {1'b0, bus.p_p1_p0};
            // Modular subtraction in LW bits gives the correct two's-complement value.
            lh1_d = {2'b00, bus.p_p0_p0, 1'b0} - {3'b000, bus.p_p0_m2} - {3'b000, bus.p_p0_p2};
            lv1_d = {2'b00, bus.p_p0_p0, 1'b0} - {3'b000, bus.p_m2_p0} - {3'b000, bus.p_p2_p0};
            ah1_d = (bus.p_p0_m1 >= bus.p_p0_p1) ? (bus.p_p0_m1 - bus.p_p0_p1)
                                                 : (bus.p_p0_p1 - bus.p_p0_m1);
            av1_d = (bus.p_m1_p0 >= bus.p_p1_p0) ? (bus.p_m1_p0 - bus.p_p1_p0)
                                                 : (bus.p_p1_p0 - bus.p_m1_p0);

            v2_d   = v1_q;
            g2_d   = g1_q;
            c2_d   = c1_q;
            nh2_d  = {2'b00, sh1_q, 1'b0} + {lh1_q[LW-1], lh1_q};
            nv2_d  = {2'b00, sv1_q, 1'b0} + {lv1_q[LW-1], lv1_q};
            sel2_d = sel_c;

            out_valid_d = v2_q;
            green_d     = g2_q ? c2_q : res_c;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q        <= 1'b0;
            g1_q        <= 1'b0;
            c1_q        <= '0;
            th1_q       <= '0;
            sh1_q       <= '0;
            sv1_q       <= '0;
            lh1_q       <= '0;
            lv1_q       <= '0;
            ah1_q       <= '0;
            av1_q       <= '0;
            v2_q        <= 1'b0;
            g2_q        <= 1'b0;
            c2_q        <= '0;
            nh2_q       <= '0;
            nv2_q       <= '0;
            sel2_q      <= SEL_B;
            out_valid_q <= 1'b0;
            green_q     <= '0;
        end else begin
            v1_q        <= v1_d;
            g1_q        <= g1_d;
            c1_q        <= c1_d;
            th1_q       <= th1_d;
            sh1_q       <= sh1_d;
            sv1_q       <= sv1_d;
            lh1_q       <= lh1_d;
            lv1_q       <= lv1_d;
            ah1_q       <= ah1_d;
            av1_q       <= av1_d;
            v2_q        <= v2_d;
            g2_q        <= g2_d;
            c2_q        <= c2_d;
            nh2_q       <= nh2_d;
            nv2_q       <= nv2_d;
            sel2_q      <= sel2_d;
            out_valid_q <= out_valid_d;
            green_q     <= green_d;
        end
    end

`ifdef GREEN_INTERP_STATS_EN
    // Decision and site type of the word sitting in the output stage.
    logic g3_q, g3_d;
    sel_t sel3_q, sel3_d;
    logic fire;
    logic [2:0][CNT_W-1:0] cnt_all;

    always_comb begin
        g3_d   = g3_q;
        sel3_d = sel3_q;
        if (en) begin
            g3_d   = g2_q;
            sel3_d = sel2_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g3_q   <= 1'b0;
            sel3_q <= SEL_B;
        end else begin
            g3_q   <= g3_d;
            sel3_q <= sel3_d;
        end
    end

    // Count on delivery, not on acceptance, so stalled words count once.
    assign fire = out_valid_q & bus.out_ready & ~g3_q;

    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;
        always_comb begin
            cnt_d = cnt_q;
            if (cnt_clr)
                cnt_d = '0;
            else if (fire && (sel3_q == sel_t'(gi)) && (cnt_q != '1))
                cnt_d = cnt_q + CNT_W'(1);
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                cnt_q <= '0;
            else
                cnt_q <= cnt_d;
        end
        assign cnt_all[gi] = cnt_q;
    end

    assign cnt_h = cnt_all[0];
    assign cnt_v = cnt_all[1];
    assign cnt_b = cnt_all[2];
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr;
    assign cnt_h = '0;
    assign cnt_v = '0;
    assign cnt_b = '0;
`endif

endmodule

// File: tb/tb_green_interp_pipe.sv
// ---------------------------------------------------------------------------
// tb_green_interp_pipe
// Directed bench for green_interp_pipe: reset state, directional/blend
// decisions with hand-computed results, clamp limits, threshold boundary,
// green passthrough, backpressure stall, counters and mid-stream reset.
// ---------------------------------------------------------------------------
module tb_green_interp_pipe;
    localparam int PW    = 12;
    localparam int TH_W  = 8;
    localparam int CNT_W = 16;

    logic clk;
    logic rst;
    logic cnt_clr;
    logic [CNT_W-1:0] cnt_h, cnt_v, cnt_b;

    int checks = 0;
    int errors = 0;
    int eh = 0, ev = 0, eb = 0;   // expected counter values

    green_interp_pipe_if #(.PW(PW), .TH_W(TH_W)) bus ();

    green_interp_pipe #(.PW(PW), .TH_W(TH_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .cnt_clr (cnt_clr),
        .cnt_h   (cnt_h),
        .cnt_v   (cnt_v),
        .cnt_b   (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Tap order: N2 N1 S1 S2 W2 W1 E1 E2 C
    task automatic set_taps(input int n2, input int n1, input int s1, input int s2,
                            input int w2, input int w1, input int e1, input int e2,
                            input int c);
        bus.p_m2_p0 = PW'(n2);
        bus.p_m1_p0 = PW'(n1);
        bus.p_p1_p0 = PW'(s1);
        bus.p_p2_p0 = PW'(s2);
        bus.p_p0_m2 = PW'(w2);
        bus.p_p0_m1 = PW'(w1);
        bus.p_p0_p1 = PW'(e1);
        bus.p_p0_p2 = PW'(e2);
        bus.p_p0_p0 = PW'(c);
    endtask

    // Send one window with out_ready high; check latency and result.
    // sel: 0=H 1=V 2=B 3=not counted.
    task automatic run_one(input string tag, input int is_g, input int th,
                           input int exp_green, input int sel);
        int lat;
        @(negedge clk);
        bus.in_is_green = is_g[0];
        bus.dir_th      = TH_W'(th);
        bus.in_valid    = 1'b1;
        #1;
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        lat = 0;
        do begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            lat++;
        end while (!bus.out_valid && lat < 10);
        chk({tag, "_latency"}, 32'(lat), 32'd3);
        chk({tag, "_green"}, 32'(bus.green), 32'(exp_green));
        $display("window %s: green=%0d latency=%0d", tag, bus.green, lat);
`ifdef GREEN_INTERP_STATS_EN
        if (sel == 0) eh++;
        if (sel == 1) ev++;
        if (sel == 2) eb++;
`else
        if (sel > 3) $display("unexpected sel code %0d", sel);
`endif
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_cnt_h"}, 32'(cnt_h), 32'(eh));
        chk({tag, "_cnt_v"}, 32'(cnt_v), 32'(ev));
        chk({tag, "_cnt_b"}, 32'(cnt_b), 32'(eb));
    endtask

    int vals [8];
    int sent, rd;
    logic [PW-1:0] held_g;
    logic held_v;

    initial begin
        rst = 1'b1;
        cnt_clr = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_is_green = 1'b0;
        bus.dir_th = '0;
        bus.out_ready = 1'b1;
        set_taps(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_green", 32'(bus.green), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk_counters("rst");

        // Flat field: dh=dv=0 -> blend -> 1000
        set_taps(1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000);
        run_one("flat", 0, 0, 1000, 2);
        @(negedge clk);
        chk_counters("flat");

        // Horizontal edge: dh=4000 dv=0 -> V -> 2000
        set_taps(2000, 2000, 2000, 2000, 0, 0, 4000, 4000, 2000);
        run_one("hedge", 0, 10, 2000, 1);

        // Vertical edge with distinct estimates: dh=0 dv=4000 -> H, Gh=1000 Gv=2000
        set_taps(0, 0, 4000, 4000, 2000, 1000, 1000, 2000, 2000);
        run_one("vedge", 0, 10, 1000, 0);

        // Overflow clamp: Nv>>2=6142 -> 4095
        set_taps(0, 4095, 4095, 0, 0, 0, 4095, 0, 4095);
        run_one("ovf", 0, 0, 4095, 1);

        // Underflow clamp: Nv>>2=-2048 -> 0
        set_taps(4095, 0, 0, 4095, 4095, 0, 4095, 4095, 0);
        run_one("udf", 0, 0, 0, 1);

        // Tie dh=dv=1 with large threshold, Gh=100 Gv=301 -> (100+301+1)>>1=201
        set_taps(500, 301, 302, 500, 500, 100, 101, 500, 500);
        run_one("tie", 0, 50, 201, 2);

        // Threshold boundary: dh=0 dv=10, Gh=1000 Gv=1002
        set_taps(995, 1000, 1000, 995, 1000, 1000, 1000, 1000, 1000);
        run_one("th_eq", 0, 10, 1001, 2);      // 0+10<10 false -> blend
        set_taps(995, 1000, 1000, 995, 1000, 1000, 1000, 1000, 1000);
        run_one("th_lt", 0, 9, 1000, 0);       // 0+9<10 -> H

        // Green passthrough with random neighbours
        set_taps($urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095),
                 $urandom_range(0, 4095), $urandom_range(0, 4095), $urandom_range(0, 4095),
                 $urandom_range(0, 4095), $urandom_range(0, 4095), 1234);
        run_one("green_site", 1, 0, 1234, 3);
        @(negedge clk);
        chk_counters("after_directed");

        // Plain synchronous clear
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        eh = 0; ev = 0; eb = 0;
        chk_counters("clr");

        // Clear coincident with a delivery -> 0
        set_taps(700, 700, 700, 700, 700, 700, 700, 700, 700);
        run_one("clr_inc", 0, 0, 700, 3);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk_counters("clr_inc");

        // Backpressure: 8 flat windows, out_ready low on cycles 5 and 6
        for (int i = 0; i < 8; i++) vals[i] = 300 + 400 * i;
        sent = 0;
        rd = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge clk);
            bus.out_ready = !(cyc == 5 || cyc == 6);
            bus.in_is_green = 1'b0;
            bus.dir_th = '0;
            if (sent < 8) begin
                set_taps(vals[sent], vals[sent], vals[sent], vals[sent], vals[sent],
                         vals[sent], vals[sent], vals[sent], vals[sent]);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (cyc == 5) begin
                held_g = bus.green;
                held_v = bus.out_valid;
                chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
                chk("stall_in_ready0", 32'(bus.in_ready), 32'd0);
            end
            if (cyc == 6) begin
                chk("stall_green_hold", 32'(bus.green), 32'(held_g));
                chk("stall_valid_hold", 32'(bus.out_valid), 32'(held_v));
                chk("stall_in_ready1", 32'(bus.in_ready), 32'd0);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (rd < 8) begin
                    chk($sformatf("stream_%0d", rd), 32'(bus.green), 32'(vals[rd]));
                    $display("stream result %0d: green=%0d", rd, bus.green);
                end
`ifdef GREEN_INTERP_STATS_EN
                eb++;
`endif
                rd++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
        end
        chk("stream_count", 32'(rd), 32'd8);
        chk_counters("stream");

        // Reset with two windows in flight
        bus.out_ready = 1'b1;
        @(negedge clk);
        set_taps(1500, 1500, 1500, 1500, 1500, 1500, 1500, 1500, 1500);
        bus.in_valid = 1'b1;
        @(negedge clk);
        set_taps(2500, 2500, 2500, 2500, 2500, 2500, 2500, 2500, 2500);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
        $display("mid-stream reset: out_valid=%0d", bus.out_valid);
        @(negedge clk);
        rst = 1'b0;
        eh = 0; ev = 0; eb = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_valid_%0d", k), 32'(bus.out_valid), 32'd0);
        end
        chk_counters("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
